// File: rtl/alu_flags.sv
// ALU with registered carry/zero flags and an optional interrupt shadow copy of the flags.
// Define SHADOW_FLAGS_EN to build the shadow C,Z registers (save on FLG_SHAD_LD, reload on FLG_RESTORE).
module alu_flags #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [3:0]        ALU_SEL,
    input  logic              FLG_LD,
    input  logic              FLG_C_SET,
    input  logic              FLG_C_CLR,
    input  logic              FLG_SHAD_LD,
    input  logic              FLG_RESTORE,
    output logic [DATA_W-1:0] RESULT,
    output logic              C_FLAG,
    output logic              Z_FLAG
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADDC = 4'd1,
        OP_SUB  = 4'd2,
        OP_SUBC = 4'd3,
        OP_CMP  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_EXOR = 4'd7,
        OP_TEST = 4'd8,
        OP_LSL  = 4'd9,
        OP_LSR  = 4'd10,
        OP_ROL  = 4'd11,
        OP_ROR  = 4'd12,
        OP_ASR  = 4'd13,
        OP_MOV  = 4'd14,
        OP_RSVD = 4'd15
    } alu_op_e;

    alu_op_e           op;
    logic              cin;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   dif_ext;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cy;
    logic              alu_z;

    assign op = alu_op_e'(ALU_SEL);

    // Only the with-carry forms fold the current carry flag into the arithmetic.
    assign cin = ((op == OP_ADDC) || (op == OP_SUBC)) ? C_FLAG : 1'b0;

    // One extra bit holds carry-out for add and borrow for subtract.
    assign sum_ext = {1'b0, A} + {1'b0, B} + {{DATA_W{1'b0}}, cin};
    assign dif_ext = {1'b0, A} - {1'b0, B} - {{DATA_W{1'b0}}, cin};

    always_comb begin
        alu_res = '0;
        alu_cy  = 1'b0;
        case (op)
            OP_ADD, OP_ADDC: begin
                alu_res = sum_ext[DATA_W-1:0];
                alu_cy  = sum_ext[DATA_W];
            end
            OP_SUB, OP_SUBC, OP_CMP: begin
                alu_res = dif_ext[DATA_W-1:0];
                alu_cy  = dif_ext[DATA_W];
            end
            OP_AND, OP_TEST: alu_res = A & B;
            OP_OR:           alu_res = A | B;
            OP_EXOR:         alu_res = A ^ B;
            OP_LSL: begin
                alu_res = {A[DATA_W-2:0], C_FLAG};
                alu_cy  = A[DATA_W-1];
            end
            OP_LSR: begin
                alu_res = {C_FLAG, A[DATA_W-1:1]};
                alu_cy  = A[0];
            end
            OP_ROL: begin
                alu_res = {A[DATA_W-2:0], A[DATA_W-1]};
                alu_cy  = A[DATA_W-1];
            end
            OP_ROR: begin
                alu_res = {A[0], A[DATA_W-1:1]};
                alu_cy  = A[0];
            end
            OP_ASR: begin
                alu_res = {A[DATA_W-1], A[DATA_W-1:1]};
                alu_cy  = A[0];
            end
            OP_MOV: begin
                alu_res = B;
                alu_cy  = C_FLAG;
            end
            default: begin
                alu_res = '0;
                alu_cy  = 1'b0;
            end
        endcase
    end

    assign alu_z  = ~|alu_res;
    assign RESULT = alu_res;

    logic restore_act;
    logic shad_c;
    logic shad_z;

`ifdef SHADOW_FLAGS_EN
    logic shad_c_q;
    logic shad_z_q;

    // Shadow always captures the pre-edge flags, so save+restore on one edge swaps them.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shad_c_q <= 1'b0;
            shad_z_q <= 1'b0;
        end else if (FLG_SHAD_LD) begin
            shad_c_q <= C_FLAG;
            shad_z_q <= Z_FLAG;
        end
    end

    assign restore_act = FLG_RESTORE;
    assign shad_c      = shad_c_q;
    assign shad_z      = shad_z_q;
`else
    logic unused_shadow_ports;

    assign unused_shadow_ports = FLG_SHAD_LD ^ FLG_RESTORE;
    assign restore_act         = 1'b0;
    assign shad_c              = 1'b0;
    assign shad_z              = 1'b0;
`endif

    // Restore wins outright; otherwise clear beats set for C, and Z only follows FLG_LD.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            C_FLAG <= 1'b0;
            Z_FLAG <= 1'b0;
        end else if (restore_act) begin
            C_FLAG <= shad_c;
            Z_FLAG <= shad_z;
        end else begin
            if (FLG_C_CLR) begin
                C_FLAG <= 1'b0;
            end else if (FLG_C_SET) begin
                C_FLAG <= 1'b1;
            end else if (FLG_LD) begin
                C_FLAG <= alu_cy;
            end
            if (FLG_LD) begin
                Z_FLAG <= alu_z;
            end
        end
    end

endmodule

// File: tb/tb_alu_flags.sv
// Bench for alu_flags: directed vectors, arithmetic reference model, per-cycle compare on the falling edge.
module tb_alu_flags;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;
    localparam int TOPB = 1 << (W - 1);

    localparam int ADD = 0, ADDC = 1, SUB = 2, SUBC = 3, CMP = 4, AND_ = 5, OR_ = 6, EXOR = 7;
    localparam int TEST = 8, LSL = 9, LSR = 10, ROL = 11, ROR = 12, ASR = 13, MOV = 14, RSVD = 15;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   ALU_SEL;
    logic         FLG_LD;
    logic         FLG_C_SET;
    logic         FLG_C_CLR;
    logic         FLG_SHAD_LD;
    logic         FLG_RESTORE;
    logic [W-1:0] RESULT;
    logic         C_FLAG;
    logic         Z_FLAG;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    // Reference flag state, including the shadow pair.
    int c_m  = 0;
    int z_m  = 0;
    int sc_m = 0;
    int sz_m = 0;

    always #5 CLK = ~CLK;

    alu_flags #(.DATA_W(W)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .A           (A),
        .B           (B),
        .ALU_SEL     (ALU_SEL),
        .FLG_LD      (FLG_LD),
        .FLG_C_SET   (FLG_C_SET),
        .FLG_C_CLR   (FLG_C_CLR),
        .FLG_SHAD_LD (FLG_SHAD_LD),
        .FLG_RESTORE (FLG_RESTORE),
        .RESULT      (RESULT),
        .C_FLAG      (C_FLAG),
        .Z_FLAG      (Z_FLAG)
    );

    // Plain integer arithmetic: result modulo 2^W, carry/borrow decided by magnitude.
    function automatic void model_alu(input int sel, input int a, input int b, input int c,
                                      output int res, output int cy);
        res = 0;
        cy  = 0;
        case (sel)
            ADD:  begin res = (a + b) & MASK;         cy = (a + b > MASK) ? 1 : 0; end
            ADDC: begin res = (a + b + c) & MASK;     cy = (a + b + c > MASK) ? 1 : 0; end
            SUB, CMP: begin res = (a - b) & MASK;     cy = (a < b) ? 1 : 0; end
            SUBC: begin res = (a - b - c) & MASK;     cy = (a < b + c) ? 1 : 0; end
            AND_, TEST: res = a & b;
            OR_:  res = a | b;
            EXOR: res = a ^ b;
            LSL:  begin res = ((a * 2) + c) & MASK;   cy = a / TOPB; end
            LSR:  begin res = (a / 2) + c * TOPB;     cy = a % 2; end
            ROL:  begin res = ((a * 2) + a / TOPB) & MASK; cy = a / TOPB; end
            ROR:  begin res = (a / 2) + (a % 2) * TOPB;    cy = a % 2; end
            ASR:  begin res = (a / 2) + (a / TOPB) * TOPB; cy = a % 2; end
            MOV:  begin res = b; cy = c; end
            default: begin res = 0; cy = 0; end
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int sel, input int a, input int b, input bit ld = 0,
                         input bit cs = 0, input bit cc = 0, input bit sh = 0, input bit rs = 0);
        ALU_SEL     = 4'(sel);
        A           = W'(a);
        B           = W'(b);
        FLG_LD      = ld;
        FLG_C_SET   = cs;
        FLG_C_CLR   = cc;
        FLG_SHAD_LD = sh;
        FLG_RESTORE = rs;
    endtask

    // Advance one rising edge and move the reference flags by the documented priorities.
    task automatic tick();
        int res, cy, nc, nz;
        @(posedge CLK);
        if (RST_N) begin
            model_alu(int'(ALU_SEL), int'(A), int'(B), c_m, res, cy);
            nc = c_m;
            nz = z_m;
            if (FLG_LD) begin
                nc = cy;
                nz = (res == 0) ? 1 : 0;
            end
            if (FLG_C_SET) nc = 1;
            if (FLG_C_CLR) nc = 0;
`ifdef SHADOW_FLAGS_EN
            if (FLG_RESTORE) begin
                nc = sc_m;
                nz = sz_m;
            end
            if (FLG_SHAD_LD) begin
                sc_m = c_m;
                sz_m = z_m;
            end
`endif
            c_m = nc;
            z_m = nz;
        end
        #1;
    endtask

    always @(negedge CLK) begin
        int res, cy;
        if (cmp_en) begin
            model_alu(int'(ALU_SEL), int'(A), int'(B), c_m, res, cy);
            chk("result", int'(RESULT), res);
            chk("c_flag", int'(C_FLAG), c_m);
            chk("z_flag", int'(Z_FLAG), z_m);
        end
    end

    int pat_a [4] = '{'h00, 'hFF, 'h55, 'h80};
    int pat_b [4] = '{'h00, 'hFF, 'hAA, 'h7F};

    initial begin
        RST_N = 1'b0;
        drive(MOV, 0, 0);
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_c", int'(C_FLAG), 0);
        chk("reset_z", int'(Z_FLAG), 0);
        RST_N  = 1'b1;
        cmp_en = 1'b1;

        // Signed overflow without carry.
        drive(ADD, 'h7F, 'h01, 1); #1;
        chk("add_7f_res", int'(RESULT), 'h80);
        tick();
        chk("add_7f_c", int'(C_FLAG), 0);
        chk("add_7f_z", int'(Z_FLAG), 0);

        // Wrap-around, then carry consumed by ADDC.
        drive(ADD, 'hFF, 'h01, 1); #1;
        chk("add_ff_res", int'(RESULT), 'h00);
        tick();
        chk("add_ff_c", int'(C_FLAG), 1);
        chk("add_ff_z", int'(Z_FLAG), 1);
        drive(ADDC, 'h10, 'h00); #1;
        chk("addc_res", int'(RESULT), 'h11);
        tick();

        // Compare with borrow, then set+clear together clears C and keeps Z.
        drive(CMP, 'h05, 'h06, 1); #1;
        chk("cmp_res", int'(RESULT), 'hFF);
        tick();
        chk("cmp_c", int'(C_FLAG), 1);
        chk("cmp_z", int'(Z_FLAG), 0);
        drive(ADD, 'hFF, 'h01, 1); tick();
        drive(MOV, 0, 0, 0, 1, 1); tick();
        chk("setclr_c", int'(C_FLAG), 0);
        chk("setclr_z", int'(Z_FLAG), 1);

        // Shifts with C=1.
        drive(MOV, 0, 0, 0, 1); tick();
        drive(LSR, 'h81, 0, 1); #1;
        chk("lsr_res", int'(RESULT), 'hC0);
        tick();
        chk("lsr_cy", int'(C_FLAG), 1);
        drive(ROL, 'h81, 0, 1); #1;
        chk("rol_res", int'(RESULT), 'h03);
        tick();
        chk("rol_cy", int'(C_FLAG), 1);
        drive(ASR, 'h81, 0); #1;
        chk("asr_res", int'(RESULT), 'hC0);
        tick();
        drive(SUBC, 'h05, 'h05, 1); #1;
        chk("subc_res", int'(RESULT), 'hFF);
        tick();
        chk("subc_c", int'(C_FLAG), 1);

        // Priority: clear beats load, set beats load, Z still loads.
        drive(ADD, 'hFF, 'h01, 1, 0, 1); tick();
        chk("clr_over_ld_c", int'(C_FLAG), 0);
        chk("clr_over_ld_z", int'(Z_FLAG), 1);
        drive(OR_, 'h01, 'h00, 1, 1, 0); tick();
        chk("set_over_ld_c", int'(C_FLAG), 1);
        chk("set_over_ld_z", int'(Z_FLAG), 0);

        // Reserved code.
        drive(RSVD, 'hFF, 'hFF, 1); #1;
        chk("rsvd_res", int'(RESULT), 0);
        tick();
        chk("rsvd_c", int'(C_FLAG), 0);
        chk("rsvd_z", int'(Z_FLAG), 1);

        // Every opcode over a small operand table, alternating loads and C forcing.
        for (int s = 0; s < 16; s++) begin
            for (int k = 0; k < 4; k++) begin
                drive(s, pat_a[k], pat_b[k], (k != 2), (k == 1), (k == 3 && s[0]));
                tick();
            end
        end

`ifdef SHADOW_FLAGS_EN
        drive(ADD, 'h7F, 'h01, 1); tick();
        drive(MOV, 0, 0, 0, 1); tick();
        drive(AND_, 'h00, 'h5A, 1, 0, 0, 1); tick();
        chk("shad_ld_c", int'(C_FLAG), 0);
        chk("shad_ld_z", int'(Z_FLAG), 1);
        drive(MOV, 0, 0, 0, 0, 0, 0, 1); tick();
        chk("restore_c", int'(C_FLAG), 1);
        chk("restore_z", int'(Z_FLAG), 0);
        drive(AND_, 'h00, 'h00, 1); tick();
        drive(MOV, 0, 0, 0, 0, 0, 1, 1); tick();
        chk("swap_c", int'(C_FLAG), 1);
        chk("swap_z", int'(Z_FLAG), 0);
        drive(MOV, 0, 0, 0, 0, 0, 0, 1); tick();
        chk("swap_back_c", int'(C_FLAG), 0);
        chk("swap_back_z", int'(Z_FLAG), 1);
`else
        drive(ADD, 'hFF, 'h01, 1); tick();
        drive(MOV, 0, 0, 0, 0, 0, 1, 1); tick();
        chk("noshadow_c", int'(C_FLAG), 1);
        chk("noshadow_z", int'(Z_FLAG), 1);
`endif

        // Asynchronous reset in the middle of a cycle, held across a loading edge.
        drive(ADD, 'hFF, 'h01, 1); tick();
        #2;
        RST_N = 1'b0;
        c_m = 0; z_m = 0; sc_m = 0; sz_m = 0;
        #1;
        chk("async_rst_c", int'(C_FLAG), 0);
        chk("async_rst_z", int'(Z_FLAG), 0);
        drive(ADD, 'hFF, 'h01, 1, 1); #1;
        chk("rst_res_comb", int'(RESULT), 'h00);
        tick();
        chk("rst_hold_c", int'(C_FLAG), 0);
        RST_N = 1'b1;
        drive(ADD, 'hFF, 'h01, 1); tick();
        chk("post_rst_c", int'(C_FLAG), 1);
        chk("post_rst_z", int'(Z_FLAG), 1);
        drive(MOV, 'h3C, 0); tick();

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_flags.md
ALU_FLAGS -- requirements
Module: alu_flags

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath width in bits.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port A  input  DATA_W  first operand, from register file DX_OUT.
REQ-005 SHALL have port B  input  DATA_W  second operand, register file DY_OUT or immediate, selected upstream.
REQ-006 SHALL have port ALU_SEL  input  4  operation select.
REQ-007 SHALL have port FLG_LD  input  1  load C and Z from ALU outcome.
REQ-008 SHALL have port FLG_C_SET / FLG_C_CLR  input  1 each  force C to 1 / 0.
REQ-009 SHALL have port FLG_SHAD_LD  input  1  save C,Z into shadow (interrupt entry).
REQ-010 SHALL have port FLG_RESTORE  input  1  reload C,Z from shadow (interrupt return).
REQ-011 SHALL have port RESULT  output  DATA_W  ALU result, to register file DIN.
REQ-012 SHALL have port C_FLAG / Z_FLAG  output  1 each  registered carry / zero flags.

Function
REQ-013 RESULT SHALL be combinational from A, B, ALU_SEL, C_FLAG: zero-cycle latency.
REQ-014 Encodings: 0 ADD A+B; 1 ADDC A+B+C_FLAG; 2 SUB A-B; 3 SUBC A-B-C_FLAG; 4 CMP A-B; 5 AND; 6 OR; 7 EXOR; 8 TEST A&B; 9 LSL {A[W-2:0],C_FLAG}; 10 LSR {C_FLAG,A[W-1:1]}; 11 ROL {A[W-2:0],A[W-1]}; 12 ROR {A[0],A[W-1:1]}; 13 ASR {A[W-1],A[W-1:1]}; 14 MOV B; 15 reserved.
REQ-015 Arithmetic SHALL use DATA_W+1 bits; carry-out = bit DATA_W; for SUB/SUBC/CMP carry-out = borrow (1 when unsigned A < B+cin).
REQ-016 Logic ops (5-8) SHALL give carry-out 0; shifts SHALL give carry-out = bit shifted out (A[W-1] for LSL/ROL, A[0] for LSR/ROR/ASR).
REQ-017 MOV SHALL give carry-out = C_FLAG (carry preserved); reserved code SHALL give RESULT 0, carry-out 0.
REQ-018 Zero-out SHALL be 1 iff the DATA_W-bit result is all-zero (CMP/TEST compute it from the unwritten difference/AND).
REQ-019 Flag update priority per edge: FLG_RESTORE > (FLG_C_CLR > FLG_C_SET for C only) > FLG_LD > hold.
REQ-020 FLG_LD SHALL load C_FLAG<=carry-out, Z_FLAG<=zero-out; Z_FLAG SHALL be unaffected by FLG_C_SET/FLG_C_CLR.
REQ-021 FLG_C_SET and FLG_C_CLR together SHALL clear C.
REQ-022 FLG_SHAD_LD SHALL capture pre-edge C_FLAG,Z_FLAG, independent of any concurrent flag update.
REQ-023 FLG_SHAD_LD with FLG_RESTORE same edge SHALL swap: shadow gets old flags, flags get old shadow.
REQ-024 Wrap-around (e.g. 0xFF+0x01) SHALL yield RESULT 0x00, carry-out 1, zero-out 1; no saturation.

Reset
REQ-025 RST_N low SHALL immediately clear C_FLAG, Z_FLAG and both shadow bits, regardless of CLK.
REQ-026 RST_N low SHALL override all control inputs; the first rising edge after release SHALL act normally.
REQ-027 RESULT SHALL remain combinational during reset (reflects A, B, ALU_SEL with C_FLAG=0).

Configuration
REQ-028 Macro SHADOW_FLAGS_EN defined SHALL include the shadow C,Z registers and REQ-009/010/022/023 behaviour.
REQ-029 Without SHADOW_FLAGS_EN, ports FLG_SHAD_LD and FLG_RESTORE SHALL remain present but be ignored; no shadow state exists.

Verification
REQ-030 A=0x7F,B=0x01,ADD,FLG_LD -> RESULT 0x80 same cycle; after edge C=0,Z=0.
REQ-031 A=0xFF,B=0x01,ADD,FLG_LD -> RESULT 0x00; after edge C=1,Z=1; then ADDC A=0x10,B=0x00 -> RESULT 0x11.
REQ-032 A=0x05,B=0x06,CMP,FLG_LD -> RESULT 0xFF; after edge C=1,Z=0; FLG_C_SET+FLG_C_CLR same edge -> C=0, Z unchanged.
REQ-033 C=1, A=0x81, LSR -> RESULT 0xC0, carry-out 1; ROL A=0x81 -> RESULT 0x03, carry-out 1; ASR A=0x81 -> 0xC0.
REQ-034 (SHADOW_FLAGS_EN) C=1,Z=0; FLG_SHAD_LD with FLG_LD from AND 0x00 -> flags C=0,Z=1; FLG_RESTORE -> C=1,Z=0; simultaneous SHAD_LD+RESTORE swaps.
REQ-035 Flags C=1,Z=1; assert RST_N low mid-cycle -> flags 0 before next edge; without SHADOW_FLAGS_EN, FLG_RESTORE leaves flags unchanged.
